// File: rtl/hazard_unit_pkg.sv
// Shared pipeline definitions for the hazard (stall/flush) controller:
// register-number width, the hard-wired zero register, and the
// mult/div busy FSM encoding.
package hazard_unit_pkg;

    localparam int PIPE_REG_W = 5;
    localparam logic [PIPE_REG_W-1:0] REG_ZERO = '0;

    typedef enum logic {
        RUN     = 1'b0,
        MD_BUSY = 1'b1
    } md_state_e;

endpackage

// File: rtl/hazard_unit_if.sv
// Bundle of pipeline-side signals seen by the hazard controller.
// slave is the controller's view, master is the pipeline (or bench) view.
interface hazard_unit_if
    import hazard_unit_pkg::*;
#(
    parameter int REG_W = PIPE_REG_W,
    parameter int CNT_W = 16
);

    logic             MemRead_ID_EX;
    logic [REG_W-1:0] RegisterRt_ID_EX;
    logic [REG_W-1:0] RegisterRs_IF_ID;
    logic [REG_W-1:0] RegisterRt_IF_ID;
    logic             UsesRt_IF_ID;
    logic             MemWr_IF_ID;
    logic             MulDiv_ID_EX;
    logic             MulDiv_IF_ID;
    logic             HiLoRead_IF_ID;
    logic             Jump_ID;
    logic             BranchTaken_EX;

    logic             PC_Wr;
    logic             IF_ID_Wr;
    logic             IF_ID_Flush;
    logic             ID_EX_Flush;
    logic             MdBusy;
    logic [CNT_W-1:0] StallCnt;

    modport slave (
        input  MemRead_ID_EX, RegisterRt_ID_EX, RegisterRs_IF_ID, RegisterRt_IF_ID,
        input  UsesRt_IF_ID, MemWr_IF_ID, MulDiv_ID_EX, MulDiv_IF_ID,
        input  HiLoRead_IF_ID, Jump_ID, BranchTaken_EX,
        output PC_Wr, IF_ID_Wr, IF_ID_Flush, ID_EX_Flush, MdBusy, StallCnt
    );

    modport master (
        output MemRead_ID_EX, RegisterRt_ID_EX, RegisterRs_IF_ID, RegisterRt_IF_ID,
        output UsesRt_IF_ID, MemWr_IF_ID, MulDiv_ID_EX, MulDiv_IF_ID,
        output HiLoRead_IF_ID, Jump_ID, BranchTaken_EX,
        input  PC_Wr, IF_ID_Wr, IF_ID_Flush, ID_EX_Flush, MdBusy, StallCnt
    );

endinterface

// File: rtl/hazard_unit_md_busy_counter.sv
// Tracks the multi-cycle HI/LO unit. A mult/div entering EX loads the
// remaining latency; the unit reports busy until the count drains to zero.
module hazard_unit_md_busy_counter
    import hazard_unit_pkg::*;
#(
    parameter int MD_LATENCY = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    output logic busy
);

    localparam int MD_W = (MD_LATENCY > 2) ? $clog2(MD_LATENCY) : 1;
    localparam logic [MD_W-1:0] LOAD_VAL = MD_W'(MD_LATENCY - 1);

    md_state_e       state, state_nx;
    logic [MD_W-1:0] md_cnt, md_cnt_nx;

    // State and remaining-latency registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= RUN;
            md_cnt <= '0;
        end else begin
            state  <= state_nx;
            md_cnt <= md_cnt_nx;
        end
    end

    // Load on a new mult/div, otherwise count down and fall back to RUN at zero
    always_comb begin
        state_nx  = state;
        md_cnt_nx = md_cnt;
        if (start) begin
            state_nx  = MD_BUSY;
            md_cnt_nx = LOAD_VAL;
        end else if (state == MD_BUSY) begin
            md_cnt_nx = md_cnt - MD_W'(1);
            if (md_cnt == MD_W'(1)) begin
                state_nx = RUN;
            end
        end
    end

    assign busy = (state == MD_BUSY);

endmodule

// File: rtl/hazard_unit.sv
// Stall/flush controller for the 5-stage pipeline. Covers the hazards the
// forwarding network cannot: load-use bubbles, the mult/div HI/LO interlock,
// and wrong-path flushes for jumps (ID) and taken branches (EX).
module hazard_unit
    import hazard_unit_pkg::*;
#(
    parameter int REG_W      = PIPE_REG_W,
    parameter int MD_LATENCY = 4,
    parameter int CNT_W      = 16
) (
    input logic          clk,
    input logic          reset,
    hazard_unit_if.slave hz
);

    logic             md_busy;
    logic             rt_ex_live;
    logic             rs_hit;
    logic             rt_hit;
    logic             lu;
    logic             md;
    logic             stall;
    logic             pc_wr;
    logic             if_id_wr;
    logic             if_id_flush;
    logic             id_ex_flush;
    logic [CNT_W-1:0] stall_cnt;
    logic             unused_store;

    // Saturating increment so the statistic sticks at all-ones
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    hazard_unit_md_busy_counter #(
        .MD_LATENCY(MD_LATENCY)
    ) u_md_busy_counter (
        .clk  (clk),
        .reset(reset),
        .start(hz.MulDiv_ID_EX),
        .busy (md_busy)
    );

    // A store that only uses Rt as store data is covered by MEM-stage
    // forwarding, so MemWr_IF_ID deliberately plays no part in the stall.
    assign unused_store = hz.MemWr_IF_ID;

    assign rt_ex_live = (hz.RegisterRt_ID_EX != REG_W'(REG_ZERO));
    assign rs_hit     = (hz.RegisterRt_ID_EX == hz.RegisterRs_IF_ID);
    assign rt_hit     = hz.UsesRt_IF_ID && (hz.RegisterRt_ID_EX == hz.RegisterRt_IF_ID);
    assign lu         = hz.MemRead_ID_EX && rt_ex_live && (rs_hit || rt_hit);
    assign md         = md_busy && (hz.HiLoRead_IF_ID || hz.MulDiv_IF_ID);

    // A taken branch squashes the ID instruction, so its stall never counts
    assign stall = (lu || md) && !hz.BranchTaken_EX;

    // Prioritised pipeline control: reset, taken branch, stall, jump, normal
    always_comb begin
        pc_wr       = 1'b1;
        if_id_wr    = 1'b1;
        if_id_flush = 1'b0;
        id_ex_flush = 1'b0;
        if (reset) begin
            pc_wr       = 1'b0;
            if_id_wr    = 1'b0;
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
        end else if (hz.BranchTaken_EX) begin
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
        end else if (lu || md) begin
            pc_wr       = 1'b0;
            if_id_wr    = 1'b0;
            id_ex_flush = 1'b1;
        end else if (hz.Jump_ID) begin
            if_id_flush = 1'b1;
        end
    end

    // Stall-cycle statistic
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt <= '0;
        end else if (stall) begin
            stall_cnt <= sat_inc(stall_cnt);
        end
    end

    assign hz.PC_Wr       = pc_wr;
    assign hz.IF_ID_Wr    = if_id_wr;
    assign hz.IF_ID_Flush = if_id_flush;
    assign hz.ID_EX_Flush = id_ex_flush;
    assign hz.MdBusy      = md_busy;
    assign hz.StallCnt    = stall_cnt;

endmodule

// File: tb/tb_hazard_unit.sv
// Directed bench for hazard_unit. Inputs change on the falling edge;
// combinational outputs are sampled 1ns later, registered ones on the
// following falling edge.
module tb_hazard_unit;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_checks = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    hazard_unit_if #(.REG_W(5), .CNT_W(16)) hz ();
    hazard_unit_if #(.REG_W(5), .CNT_W(2))  hz2 ();

    hazard_unit #(.REG_W(5), .MD_LATENCY(4), .CNT_W(16)) dut (
        .clk  (clk),
        .reset(reset),
        .hz   (hz)
    );

    hazard_unit #(.REG_W(5), .MD_LATENCY(4), .CNT_W(2)) dut_sat (
        .clk  (clk),
        .reset(reset),
        .hz   (hz2)
    );

    // {PC_Wr, IF_ID_Wr, IF_ID_Flush, ID_EX_Flush}
    logic [3:0] ctl;
    assign ctl = {hz.PC_Wr, hz.IF_ID_Wr, hz.IF_ID_Flush, hz.ID_EX_Flush};

    task automatic set_in(input logic mr, input logic [4:0] rt_ex, input logic [4:0] rs_id,
                          input logic [4:0] rt_id, input logic uses_rt, input logic mem_wr,
                          input logic md_ex, input logic md_id, input logic hilo,
                          input logic jmp, input logic br);
        hz.MemRead_ID_EX    = mr;
        hz.RegisterRt_ID_EX = rt_ex;
        hz.RegisterRs_IF_ID = rs_id;
        hz.RegisterRt_IF_ID = rt_id;
        hz.UsesRt_IF_ID     = uses_rt;
        hz.MemWr_IF_ID      = mem_wr;
        hz.MulDiv_ID_EX     = md_ex;
        hz.MulDiv_IF_ID     = md_id;
        hz.HiLoRead_IF_ID   = hilo;
        hz.Jump_ID          = jmp;
        hz.BranchTaken_EX   = br;
    endtask

    task automatic idle();
        set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        @(negedge clk);
        #1;
        n_checks++;
        if (ctl !== 4'b0011) begin
            n_fail++;
            $display("FAIL reset_ctl: got %b want %b", ctl, 4'b0011);
        end
        n_checks++;
        if (hz.MdBusy !== 1'b0 || hz.StallCnt !== 16'd0) begin
            n_fail++;
            $display("FAIL reset_state: got busy=%b cnt=%0d want busy=0 cnt=0", hz.MdBusy, hz.StallCnt);
        end
        @(negedge clk);
        reset = 1'b0;
        #1;
        n_checks++;
        if (ctl !== 4'b1100) begin
            n_fail++;
            $display("FAIL run_idle_ctl: got %b want %b", ctl, 4'b1100);
        end
    endtask

    task automatic test_load_use();
        // lw $2 in EX, add with Rs=$2 in ID
        @(negedge clk);
        set_in(1'b1, 5'd2, 5'd2, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        n_checks++;
        if (ctl !== 4'b0001) begin
            n_fail++;
            $display("FAIL lu_rs_ctl: got %b want %b", ctl, 4'b0001);
        end
        @(negedge clk);
        idle();
        #1;
        n_checks++;
        if (hz.StallCnt !== 16'd1 || ctl !== 4'b1100) begin
            n_fail++;
            $display("FAIL lu_rs_after: got cnt=%0d ctl=%b want cnt=1 ctl=1100", hz.StallCnt, ctl);
        end
        // Rt operand match
        @(negedge clk);
        set_in(1'b1, 5'd2, 5'd9, 5'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        n_checks++;
        if (ctl !== 4'b0001) begin
            n_fail++;
            $display("FAIL lu_rt_ctl: got %b want %b", ctl, 4'b0001);
        end
        @(negedge clk);
        idle();
        #1;
        n_checks++;
        if (hz.StallCnt !== 16'd2) begin
            n_fail++;
            $display("FAIL lu_rt_cnt: got %0d want %0d", hz.StallCnt, 2);
        end
    endtask

    task automatic test_no_stall();
        // lw $2 -> sw with Rt=$2 as store data only
        @(negedge clk);
        set_in(1'b1, 5'd2, 5'd3, 5'd2, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        n_checks++;
        if (ctl !== 4'b1100) begin
            n_fail++;
            $display("FAIL sw_data_ctl: got %b want %b", ctl, 4'b1100);
        end
        // lw $0 with Rs=$0
        @(negedge clk);
        set_in(1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        n_checks++;
        if (ctl !== 4'b1100) begin
            n_fail++;
            $display("FAIL lw_zero_ctl: got %b want %b", ctl, 4'b1100);
        end
        // register match without a load in EX
        @(negedge clk);
        set_in(1'b0, 5'd4, 5'd4, 5'd4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        n_checks++;
        if (ctl !== 4'b1100) begin
            n_fail++;
            $display("FAIL no_load_ctl: got %b want %b", ctl, 4'b1100);
        end
        @(negedge clk);
        idle();
        #1;
        n_checks++;
        if (hz.StallCnt !== 16'd2) begin
            n_fail++;
            $display("FAIL no_stall_cnt: got %0d want %0d", hz.StallCnt, 2);
        end
    endtask

    task automatic test_muldiv();
        @(negedge clk);
        set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        n_checks++;
        if (ctl !== 4'b1100 || hz.MdBusy !== 1'b0) begin
            n_fail++;
            $display("FAIL md_start: got ctl=%b busy=%b want ctl=1100 busy=0", ctl, hz.MdBusy);
        end
        // mflo in ID: three stall cycles
        @(negedge clk);
        set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            #1;
            n_checks++;
            if (ctl !== 4'b0001 || hz.MdBusy !== 1'b1) begin
                n_fail++;
                $display("FAIL md_stall_%0d: got ctl=%b busy=%b want ctl=0001 busy=1", i, ctl, hz.MdBusy);
            end
            @(negedge clk);
        end
        #1;
        n_checks++;
        if (ctl !== 4'b1100 || hz.MdBusy !== 1'b0 || hz.StallCnt !== 16'd5) begin
            n_fail++;
            $display("FAIL md_release: got ctl=%b busy=%b cnt=%0d want ctl=1100 busy=0 cnt=5",
                     ctl, hz.MdBusy, hz.StallCnt);
        end
        idle();
    endtask

    task automatic test_branch_override();
        @(negedge clk);
        set_in(1'b1, 5'd2, 5'd2, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        #1;
        n_checks++;
        if (ctl !== 4'b1111) begin
            n_fail++;
            $display("FAIL br_over_lu_ctl: got %b want %b", ctl, 4'b1111);
        end
        @(negedge clk);
        idle();
        #1;
        n_checks++;
        if (hz.StallCnt !== 16'd5) begin
            n_fail++;
            $display("FAIL br_over_lu_cnt: got %0d want %0d", hz.StallCnt, 5);
        end
    endtask

    task automatic test_jump();
        @(negedge clk);
        set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        #1;
        n_checks++;
        if (ctl !== 4'b1110) begin
            n_fail++;
            $display("FAIL jump_ctl: got %b want %b", ctl, 4'b1110);
        end
        @(negedge clk);
        idle();
        #1;
        n_checks++;
        if (ctl !== 4'b1100) begin
            n_fail++;
            $display("FAIL jump_clear_ctl: got %b want %b", ctl, 4'b1100);
        end
        // jump held behind a mult/div stall
        @(negedge clk);
        set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            #1;
            n_checks++;
            if (ctl !== 4'b0001) begin
                n_fail++;
                $display("FAIL jump_held_%0d: got %b want %b", i, ctl, 4'b0001);
            end
            @(negedge clk);
        end
        #1;
        n_checks++;
        if (ctl !== 4'b1110 || hz.StallCnt !== 16'd8) begin
            n_fail++;
            $display("FAIL jump_after_md: got ctl=%b cnt=%0d want ctl=1110 cnt=8", ctl, hz.StallCnt);
        end
        idle();
    endtask

    task automatic test_reset_mid_busy();
        @(negedge clk);
        set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        // md_cnt is now 2
        #1;
        n_checks++;
        if (hz.MdBusy !== 1'b1 || hz.StallCnt !== 16'd9) begin
            n_fail++;
            $display("FAIL pre_reset: got busy=%b cnt=%0d want busy=1 cnt=9", hz.MdBusy, hz.StallCnt);
        end
        reset = 1'b1;
        #1;
        n_checks++;
        if (hz.MdBusy !== 1'b0 || hz.StallCnt !== 16'd0 || ctl !== 4'b0011) begin
            n_fail++;
            $display("FAIL mid_reset: got busy=%b cnt=%0d ctl=%b want busy=0 cnt=0 ctl=0011",
                     hz.MdBusy, hz.StallCnt, ctl);
        end
        @(negedge clk);
        reset = 1'b0;
        #1;
        n_checks++;
        if (hz.MdBusy !== 1'b0 || ctl !== 4'b1100) begin
            n_fail++;
            $display("FAIL post_reset: got busy=%b ctl=%b want busy=0 ctl=1100", hz.MdBusy, ctl);
        end
        idle();
        @(negedge clk);
        #1;
        n_checks++;
        if (hz.MdBusy !== 1'b0 || hz.StallCnt !== 16'd0) begin
            n_fail++;
            $display("FAIL post_reset_run: got busy=%b cnt=%0d want busy=0 cnt=0", hz.MdBusy, hz.StallCnt);
        end
    endtask

    task automatic test_saturate();
        @(negedge clk);
        hz2.MemRead_ID_EX    = 1'b1;
        hz2.RegisterRt_ID_EX = 5'd1;
        hz2.RegisterRs_IF_ID = 5'd1;
        repeat (5) @(negedge clk);
        #1;
        n_checks++;
        if (hz2.StallCnt !== 2'd3) begin
            n_fail++;
            $display("FAIL stall_cnt_sat: got %0d want %0d", hz2.StallCnt, 3);
        end
        hz2.MemRead_ID_EX = 1'b0;
    endtask

    initial begin
        idle();
        hz2.MemRead_ID_EX    = 1'b0;
        hz2.RegisterRt_ID_EX = 5'd0;
        hz2.RegisterRs_IF_ID = 5'd0;
        hz2.RegisterRt_IF_ID = 5'd0;
        hz2.UsesRt_IF_ID     = 1'b0;
        hz2.MemWr_IF_ID      = 1'b0;
        hz2.MulDiv_ID_EX     = 1'b0;
        hz2.MulDiv_IF_ID     = 1'b0;
        hz2.HiLoRead_IF_ID   = 1'b0;
        hz2.Jump_ID          = 1'b0;
        hz2.BranchTaken_EX   = 1'b0;

        test_reset();
        test_load_use();
        test_no_stall();
        test_muldiv();
        test_branch_override();
        test_jump();
        test_saturate();
        test_reset_mid_busy();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
